// File: rtl/cmp_seq_if.sv
// Bundle of request, operand, result and external-comparator signals for cmp_seq.
// The slave modport is the sequencer; the master modport is the requesters plus the comparator.
interface cmp_seq_if;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        res_gt, res_eq, res_lt;
  logic        busy;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_gt_in, cmp_eq_in, cmp_lt_in;
  logic        cmp_gt, cmp_eq, cmp_lt;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cmp_gt, cmp_eq, cmp_lt,
    output gnt0, gnt1, done0, done1, res_gt, res_eq, res_lt, busy,
           cmp_a, cmp_b, cmp_gt_in, cmp_eq_in, cmp_lt_in
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cmp_gt, cmp_eq, cmp_lt,
    input  gnt0, gnt1, done0, done1, res_gt, res_eq, res_lt, busy,
           cmp_a, cmp_b, cmp_gt_in, cmp_eq_in, cmp_lt_in
  );
endinterface

// File: rtl/cmp_seq.sv
// Two-requester 16-bit magnitude compare sequencer driving an external 4-bit cascadable
// comparator, LSB nibble first, with round-robin arbitration and a one-cycle done pulse.
module cmp_seq (
  input  logic       clk,
  input  logic       rst_n,
  cmp_seq_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] CASC_INIT = 3'b010;  // {gt, eq, lt}: "equal so far"

  state_t      r_state;
  logic [1:0]  r_nib;
  logic [2:0]  r_casc;
  logic [15:0] r_a, r_b;
  logic        r_gnt0, r_gnt1;
  logic        r_done0, r_done1;
  logic        r_last;
  logic [2:0]  r_res;

  logic        w_any, w_sel;
  logic [2:0]  w_cmp;
  logic [3:0]  w_cmp_a, w_cmp_b;
  logic [2:0]  w_casc_out;

  assign w_any = bus.req0 | bus.req1;
  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign w_sel = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_cmp = {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_nib   <= 2'd0;
      r_casc  <= CASC_INIT;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_last  <= 1'b1;
      r_res   <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= w_sel ? bus.a1 : bus.a0;
            r_b     <= w_sel ? bus.b1 : bus.b0;
            r_nib   <= 2'd0;
            r_casc  <= CASC_INIT;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
            r_last  <= w_sel;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_casc <= w_cmp;
          r_nib  <= r_nib + 2'd1;
          if (r_nib == 2'd3) begin
            r_res   <= w_cmp;
            r_done0 <= r_gnt0;
            r_done1 <= r_gnt1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_cmp_a    = 4'd0;
    w_cmp_b    = 4'd0;
    w_casc_out = CASC_INIT;
    if (r_state == S_RUN) begin
      w_cmp_a    = r_a[{r_nib, 2'b00} +: 4];
      w_cmp_b    = r_b[{r_nib, 2'b00} +: 4];
      w_casc_out = r_casc;
    end
  end

  assign bus.cmp_a     = w_cmp_a;
  assign bus.cmp_b     = w_cmp_b;
  assign bus.cmp_gt_in = w_casc_out[2];
  assign bus.cmp_eq_in = w_casc_out[1];
  assign bus.cmp_lt_in = w_casc_out[0];
  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.res_gt    = r_res[2];
  assign bus.res_eq    = r_res[1];
  assign bus.res_lt    = r_res[0];
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_cmp_seq.sv
// Directed bench for cmp_seq with a behavioural 4-bit cascadable comparator.
module tb_cmp_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  cmp_seq_if bus ();

  cmp_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nibble compare decides; an equal nibble passes the lower-order cascade through.
  always_comb begin
    if (bus.cmp_a > bus.cmp_b)
      {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} = 3'b100;
    else if (bus.cmp_a < bus.cmp_b)
      {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} = 3'b001;
    else
      {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} = {bus.cmp_gt_in, bus.cmp_eq_in, bus.cmp_lt_in};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete operation for requester r, checking grant, nibble order, done and result.
  task automatic run_op(input string tag, input bit r, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] exp, input bit mutate);
    if (r) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else   begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    tick();
    check({tag, " gnt"}, {bus.gnt1, bus.gnt0}, r ? 2'b10 : 2'b01);
    check({tag, " busy"}, bus.busy, 1'b1);
    check({tag, " casc_init"}, {bus.cmp_gt_in, bus.cmp_eq_in, bus.cmp_lt_in}, 3'b010);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (mutate) begin
      if (r) bus.a1 = ~a; else bus.a0 = ~a;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check({tag, " nibble"}, {bus.cmp_a, bus.cmp_b}, {a[4*i +: 4], b[4*i +: 4]});
      check({tag, " no_done_in_run"}, {bus.done1, bus.done0}, 2'b00);
    end
    tick();
    check({tag, " done"}, {bus.done1, bus.done0}, r ? 2'b10 : 2'b01);
    check({tag, " res"}, {bus.res_gt, bus.res_eq, bus.res_lt}, exp);
    tick();
    check({tag, " idle"}, {bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 5'b0);
    check({tag, " res_hold"}, {bus.res_gt, bus.res_eq, bus.res_lt}, exp);
    check({tag, " idle_cmp"}, {bus.cmp_a, bus.cmp_b, bus.cmp_gt_in, bus.cmp_eq_in, bus.cmp_lt_in},
          {8'h00, 3'b010});
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 16'h0; bus.b0 = 16'h0; bus.a1 = 16'h0; bus.b1 = 16'h0;

    #2;
    check("reset_async", {bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 5'b0);
    tick();
    tick();
    check("reset_res", {bus.res_gt, bus.res_eq, bus.res_lt}, 3'b000);
    check("reset_cmp", {bus.cmp_a, bus.cmp_b, bus.cmp_gt_in, bus.cmp_eq_in, bus.cmp_lt_in},
          {8'h00, 3'b010});
    rst_n = 1'b1;

    run_op("single_eq", 1'b0, 16'h1234, 16'h1234, 3'b010, 1'b0);
    run_op("upper_gt",  1'b1, 16'h8000, 16'h7FFF, 3'b100, 1'b0);
    run_op("lower_lt",  1'b1, 16'h0001, 16'h0002, 3'b001, 1'b0);

    // Tie after a fresh reset: grants alternate 0,1,0,1 exactly six cycles apart.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.a0 = 16'h0005; bus.b0 = 16'h0003;
    bus.a1 = 16'h0002; bus.b1 = 16'h0002;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("tie_gnt", {bus.gnt1, bus.gnt0}, (k % 2) ? 2'b10 : 2'b01);
      for (int j = 0; j < 4; j++) tick();
      check("tie_done", {bus.done1, bus.done0}, (k % 2) ? 2'b10 : 2'b01);
      check("tie_res", {bus.res_gt, bus.res_eq, bus.res_lt}, (k % 2) ? 3'b010 : 3'b100);
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      tick();
    end
    check("tie_end_idle", {bus.busy, bus.gnt1, bus.gnt0}, 3'b000);

    run_op("midop_change", 1'b0, 16'h00F0, 16'h00F0, 3'b010, 1'b1);

    // Reset while nib=2 aborts the operation with no done pulse.
    bus.req1 = 1'b1; bus.a1 = 16'h1111; bus.b1 = 16'h2222;
    tick();
    bus.req1 = 1'b0;
    tick();
    tick();
    check("abort_nib2", {bus.cmp_a, bus.cmp_b}, 8'h12);
    rst_n = 1'b0;
    #1;
    check("abort_clear", {bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 5'b0);
    check("abort_res", {bus.res_gt, bus.res_eq, bus.res_lt}, 3'b000);
    check("abort_cmp", {bus.cmp_a, bus.cmp_b, bus.cmp_gt_in, bus.cmp_eq_in, bus.cmp_lt_in},
          {8'h00, 3'b010});
    tick();
    tick();
    check("abort_no_done", {bus.busy, bus.done1, bus.done0}, 3'b000);
    rst_n = 1'b1;
    run_op("recover", 1'b1, 16'hABCD, 16'hABCC, 3'b100, 1'b0);

    run_op("extreme_lt", 1'b0, 16'h0000, 16'hFFFF, 3'b001, 1'b0);
    run_op("extreme_eq", 1'b1, 16'hFFFF, 16'hFFFF, 3'b010, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
